// File: rtl/sevseg_pkg.sv
// Shared types, constants and BCD-to-segment mapping for the two-digit scan driver.
// Patterns are active-high {g,f,e,d,c,b,a}; polarity is applied by the consumer.
package sevseg_pkg;

  typedef enum logic [1:0] {
    BLANK_T = 2'd0,
    SHOW_T  = 2'd1,
    BLANK_O = 2'd2,
    SHOW_O  = 2'd3
  } scan_state_t;

  localparam logic [6:0] SEG_DASH   = 7'h40;
  localparam logic [6:0] SEG_OFF_AH = 7'h00;

  // Codes 10-15 are not valid BCD and show a centre dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage : sevseg_pkg

// File: rtl/sevseg_decode.sv
// Combinational 4-bit BCD to active-high seven-segment pattern, dash for codes 10-15.
module sevseg_decode
  import sevseg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_ah_o
);

  always_comb begin
    seg_ah_o = bcd_to_seg(bcd_i);
  end

endmodule : sevseg_decode

// File: rtl/bcd2_sevseg_scan.sv
// Two-digit multiplexed seven-segment driver with dead-time blanking and frame snapshot.
// Optional SEVSEG_LEADING_ZERO_BLANK_EN: a tens digit of 0 is left dark.
module bcd2_sevseg_scan
  import sevseg_pkg::*;
#(
  parameter int unsigned PRESCALE_DIV   = 50000,
  parameter int unsigned BLANK_CYCLES   = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dcba10,
  input  logic [3:0] dcba1,
  input  logic       disp_en,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_done
);

  localparam int unsigned MAX_LEN = (PRESCALE_DIV > BLANK_CYCLES) ? PRESCALE_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_OFF_AH : SEG_OFF_AH;
  localparam logic [1:0] AN_OFF  = AN_ACTIVE_LOW  ? 2'b11 : 2'b00;

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       snap10_q, snap10_d;
  logic [3:0]       snap1_q, snap1_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;

  logic             slot_last;
  logic             frame_end;
  logic [3:0]       dec_bcd;
  logic [6:0]       dec_seg_ah;
  logic [6:0]       seg_ah;
  logic [1:0]       an_ah;

  always_comb begin
    slot_last = 1'b0;
    case (state_q)
      BLANK_T, BLANK_O: slot_last = (cnt_q == BLANK_LAST);
      SHOW_T,  SHOW_O:  slot_last = (cnt_q == SHOW_LAST);
      default:          slot_last = 1'b1;
    endcase
  end

  assign frame_end = (state_q == SHOW_O) && slot_last;

  always_comb begin
    state_d = state_q;
    if (slot_last) begin
      case (state_q)
        BLANK_T: state_d = SHOW_T;
        SHOW_T:  state_d = BLANK_O;
        BLANK_O: state_d = SHOW_O;
        SHOW_O:  state_d = BLANK_T;
        default: state_d = BLANK_T;
      endcase
    end
  end

  assign cnt_d = slot_last ? '0 : cnt_q + 1'b1;

  // Snapshot only at the frame boundary so a digit pair is never torn across slots.
  always_comb begin
    snap10_d = snap10_q;
    snap1_d  = snap1_q;
    if (frame_end) begin
      snap10_d = dcba10;
      snap1_d  = dcba1;
    end
  end

  // The snapshot is stable whenever a SHOW state is being entered, so one decoder suffices.
  assign dec_bcd = (state_d == SHOW_T) ? snap10_q : snap1_q;

  sevseg_decode u_decode (
    .bcd_i    (dec_bcd),
    .seg_ah_o (dec_seg_ah)
  );

  always_comb begin
    an_ah  = 2'b00;
    seg_ah = SEG_OFF_AH;
    if (disp_en) begin
      case (state_d)
        SHOW_T: begin
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
          if (snap10_q != 4'd0) begin
            an_ah  = 2'b10;
            seg_ah = dec_seg_ah;
          end
`else
          an_ah  = 2'b10;
          seg_ah = dec_seg_ah;
`endif
        end
        SHOW_O: begin
          an_ah  = 2'b01;
          seg_ah = dec_seg_ah;
        end
        default: begin
          an_ah  = 2'b00;
          seg_ah = SEG_OFF_AH;
        end
      endcase
    end
  end

  assign an_d  = AN_ACTIVE_LOW  ? ~an_ah  : an_ah;
  assign seg_d = SEG_ACTIVE_LOW ? ~seg_ah : seg_ah;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BLANK_T;
      cnt_q    <= '0;
      snap10_q <= '0;
      snap1_q  <= '0;
      seg_q    <= SEG_OFF;
      an_q     <= AN_OFF;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      snap10_q <= snap10_d;
      snap1_q  <= snap1_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_end;

endmodule : bcd2_sevseg_scan

// File: tb/tb_bcd2_sevseg_scan.sv
// Self-checking bench for bcd2_sevseg_scan: directed scenarios plus random traffic
// compared every cycle against a frame-position model.
module tb_bcd2_sevseg_scan;

  localparam int P = 3;
  localparam int B = 2;
  localparam int L = 2 * (B + P);

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dcba10;
  logic [3:0] dcba1;
  logic       disp_en;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_done;

  always #5 clk = ~clk;

  bcd2_sevseg_scan #(
    .PRESCALE_DIV   (P),
    .BLANK_CYCLES   (B),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dcba10     (dcba10),
    .dcba1      (dcba1),
    .disp_en    (disp_en),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: position within the frame, the displayed digit pair and the sampled enable.
  int         mp   = 0;
  logic [3:0] m10  = 4'd0;
  logic [3:0] m1   = 4'd0;
  logic       men  = 1'b0;

  logic [6:0] ref_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  task automatic check7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_check();
    logic [1:0] ean;
    logic [6:0] eseg;
    ean  = 2'b11;
    eseg = 7'h7F;
    if (men) begin
      if (mp >= B && mp < B + P) begin
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
        if (m10 != 4'd0) begin
          ean  = 2'b01;
          eseg = ~ref_tab[m10];
        end
`else
        ean  = 2'b01;
        eseg = ~ref_tab[m10];
`endif
      end else if (mp >= 2 * B + P) begin
        ean  = 2'b10;
        eseg = ~ref_tab[m1];
      end
    end
    check7("model_an",  {5'b0, an}, {5'b0, ean});
    check7("model_seg", seg, eseg);
    check7("model_frame_done", {6'b0, frame_done}, {6'b0, (mp == L - 1)});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      mp  = 0;
      m10 = 4'd0;
      m1  = 4'd0;
      men = 1'b0;
    end else begin
      if (mp == L - 1) begin
        m10 = dcba10;
        m1  = dcba1;
      end
      mp  = (mp + 1) % L;
      men = disp_en;
    end
    #1;
    cyc++;
    model_check();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    rst     = 1'b1;
    dcba10  = 4'd4;
    dcba1   = 4'd7;
    disp_en = 1'b1;

    // Basic two-frame sequence, reset snapshot shown first
    do_reset();
    check7("rst_an", {5'b0, an}, 7'h03);
    check7("rst_seg", seg, 7'h7F);
    run_to(2);  check7("f1_tens_an", {5'b0, an}, 7'h01); check7("f1_tens_seg", seg, ~7'h3F);
    run_to(5);  check7("f1_blank_o_an", {5'b0, an}, 7'h03);
    run_to(7);  check7("f1_ones_an", {5'b0, an}, 7'h02); check7("f1_ones_seg", seg, ~7'h3F);
    run_to(9);  check7("f1_frame_done", {6'b0, frame_done}, 7'h01);
    run_to(12); check7("f2_tens_seg", seg, ~7'h66);
    run_to(17); check7("f2_ones_seg", seg, ~7'h07);
    run_to(20);

    // Mid-frame input change does not tear
    dcba10 = 4'd5; dcba1 = 4'd3;
    do_reset();
    run_to(15); dcba1 = 4'd8;
    run_to(17); check7("notear_ones_seg", seg, ~7'h4F);
    run_to(27); check7("f3_ones_seg", seg, ~7'h7F);
    run_to(30);

    // Invalid BCD shows dash
    dcba10 = 4'hC; dcba1 = 4'd9;
    do_reset();
    run_to(12); check7("dash_tens_seg", seg, ~7'h40);
    run_to(17); check7("nine_ones_seg", seg, ~7'h6F);
    run_to(20);

    // Display disable keeps scan phase
    dcba10 = 4'd4; dcba1 = 4'd7;
    do_reset();
    run_to(4); disp_en = 1'b0;
    run_to(7); check7("dis_ones_an", {5'b0, an}, 7'h03);
    run_to(9); check7("dis_frame_done", {6'b0, frame_done}, 7'h01);
    check7("dis_an_c9", {5'b0, an}, 7'h03);
    disp_en = 1'b1;
    run_to(12); check7("reen_tens_an", {5'b0, an}, 7'h01); check7("reen_tens_seg", seg, ~7'h66);
    run_to(20);

    // Reset during SHOW_T aborts the frame
    dcba10 = 4'd9; dcba1 = 4'd9;
    do_reset();
    run_to(3); rst = 1'b1;
    tick();
    check7("midrst_an", {5'b0, an}, 7'h03);
    check7("midrst_fd", {6'b0, frame_done}, 7'h00);
    rst = 1'b0; cyc = 0;
    run_to(1);  check7("midrst_blank_an", {5'b0, an}, 7'h03);
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    run_to(2);  check7("midrst_tens_an", {5'b0, an}, 7'h03);
`else
    run_to(2);  check7("midrst_tens_seg", seg, ~7'h3F);
`endif
    run_to(12); check7("midrst_f2_tens_seg", seg, ~7'h6F);
    run_to(20);

    // Leading zero handling
    dcba10 = 4'd0; dcba1 = 4'd5;
    do_reset();
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    run_to(12); check7("lz_tens_an", {5'b0, an}, 7'h03); check7("lz_tens_seg", seg, 7'h7F);
`else
    run_to(12); check7("lz_tens_an", {5'b0, an}, 7'h01); check7("lz_tens_seg", seg, ~7'h3F);
`endif
    run_to(17); check7("lz_ones_seg", seg, ~7'h6D); check7("lz_ones_an", {5'b0, an}, 7'h02);
    run_to(20);

    // Random traffic including occasional resets
    do_reset();
    for (int i = 0; i < 800; i++) begin
      dcba10  = 4'($urandom_range(0, 15));
      dcba1   = 4'($urandom_range(0, 15));
      disp_en = ($urandom_range(0, 9) != 0);
      rst     = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bcd2_sevseg_scan
